// File: rtl/flash_sample_fetcher.sv
// rtl/flash_sample_fetcher.sv - flash word fetcher, 16-bit sample splitter and sample FIFO (optional SAMPLE_ATTEN_EN)
module flash_sample_fetcher #(
    parameter int NUM_WORDS  = 2097152,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    input  logic        flash_mem_waitrequest,
    input  logic [31:0] flash_mem_readdata,
    input  logic        flash_mem_readdatavalid,
    output logic        flash_mem_write,
    output logic        flash_mem_burstcount,
    output logic [3:0]  flash_mem_byteenable,
    output logic [31:0] flash_mem_writedata,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        busy,
    output logic        done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_SPLIT_LO, S_SPLIT_HI, S_ADV, S_DRAIN, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [22:0]     addr_q, addr_d;
    logic            read_q, read_d;
    logic [1:0]      mode_q, mode_d;
    logic [31:0]     word_q, word_d;
    logic            rep_q, rep_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [15:0]     mem_d [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic [15:0]     push_raw;
    logic [15:0]     push_sample;
    logic            slow;
    logic            chip;
    logic [CW-1:0]   free_w;
    logic [CW-1:0]   need_w;

    assign slow   = (mode_q == 2'b10);
    assign chip   = (mode_q == 2'b01);
    assign free_w = CW'(FIFO_DEPTH) - count_q;
    assign need_w = slow ? CW'(4) : CW'(2);
    assign pop    = (count_q != '0) && sample_ready;

`ifdef SAMPLE_ATTEN_EN
    assign push_sample = 16'($signed(push_raw) >>> 6);
`else
    assign push_sample = push_raw;
`endif

    // Next-state logic for the playback sequencer and the sample FIFO
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        read_d   = read_q;
        mode_d   = mode_q;
        word_d   = word_q;
        rep_d    = rep_q;
        busy_d   = busy_q;
        done_d   = done_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        push     = 1'b0;
        push_raw = 16'h0000;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_REQ;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    mode_d  = mode;
                    rep_d   = 1'b0;
                end
            end
            S_REQ: begin
                // Room is reserved before the read so the split never overflows
                if (read_q) begin
                    if (!flash_mem_waitrequest) begin
                        read_d  = 1'b0;
                        state_d = S_WAIT;
                    end
                end else if (free_w >= need_w) begin
                    read_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (flash_mem_readdatavalid) begin
                    word_d  = flash_mem_readdata;
                    state_d = S_SPLIT_LO;
                end
            end
            S_SPLIT_LO: begin
                push     = 1'b1;
                push_raw = word_q[15:0];
                if (slow && !rep_q) begin
                    rep_d = 1'b1;
                end else begin
                    rep_d   = 1'b0;
                    state_d = chip ? S_ADV : S_SPLIT_HI;
                end
            end
            S_SPLIT_HI: begin
                push     = 1'b1;
                push_raw = word_q[31:16];
                if (slow && !rep_q) begin
                    rep_d = 1'b1;
                end else begin
                    rep_d   = 1'b0;
                    state_d = S_ADV;
                end
            end
            S_ADV: begin
                if (addr_q == 23'(NUM_WORDS - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d  = addr_q + 23'd1;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (count_q == '0) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = push_sample;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset abandons any outstanding read and flushes the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            read_q   <= 1'b0;
            mode_q   <= 2'b00;
            word_q   <= '0;
            rep_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            read_q   <= read_d;
            mode_q   <= mode_d;
            word_q   <= word_d;
            rep_q    <= rep_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign flash_mem_read       = read_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_write      = 1'b0;
    assign flash_mem_burstcount = 1'b1;
    assign flash_mem_byteenable = 4'hF;
    assign flash_mem_writedata  = 32'h0000_0000;
    assign sample_valid         = (count_q != '0);
    assign sample_data          = mem_q[rd_ptr_q];
    assign busy                 = busy_q;
    assign done                 = done_q;

endmodule

// File: tb/tb_flash_sample_fetcher.sv
// tb/tb_flash_sample_fetcher.sv - randomized self-checking bench for flash_sample_fetcher
module tb_flash_sample_fetcher;
    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic        flash_mem_waitrequest = 1'b0;
    logic [31:0] flash_mem_readdata = '0;
    logic        flash_mem_readdatavalid = 1'b0;
    logic        flash_mem_write;
    logic        flash_mem_burstcount;
    logic [3:0]  flash_mem_byteenable;
    logic [31:0] flash_mem_writedata;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        busy;
    logic        done;

    flash_sample_fetcher #(.NUM_WORDS(NW), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .flash_mem_read(flash_mem_read), .flash_mem_address(flash_mem_address),
        .flash_mem_waitrequest(flash_mem_waitrequest), .flash_mem_readdata(flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid), .flash_mem_write(flash_mem_write),
        .flash_mem_burstcount(flash_mem_burstcount), .flash_mem_byteenable(flash_mem_byteenable),
        .flash_mem_writedata(flash_mem_writedata), .sample_data(sample_data),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [31:0] flash [NW];
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    int          wr_mode = 0;
    int          ready_mode = 0;
    int          stall_left = 0;
    int          stall_cycles = 0;
    int          acc_cnt = 0;
    int          first_acc = -1;
    int          first_valid = -1;
    logic [22:0] first_addr = '0;
    logic [22:0] max_addr = '0;
    bit          pend = 1'b0;
    int          paddr = 0;
    bit          stray_req = 1'b0;
    bit          prev_stall = 1'b0;
    logic [22:0] prev_addr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [15:0] shape(input logic [15:0] s);
`ifdef SAMPLE_ATTEN_EN
        return 16'($signed(s) >>> 6);
`else
        return s;
`endif
    endfunction

    // Reference: samples each word yields under a playback mode
    task automatic build_exp(input logic [1:0] m);
        exp_q.delete();
        for (int w = 0; w < NW; w++) begin
            if (m == 2'b01) begin
                exp_q.push_back(shape(flash[w][15:0]));
            end else if (m == 2'b10) begin
                repeat (2) exp_q.push_back(shape(flash[w][15:0]));
                repeat (2) exp_q.push_back(shape(flash[w][31:16]));
            end else begin
                exp_q.push_back(shape(flash[w][15:0]));
                exp_q.push_back(shape(flash[w][31:16]));
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Flash slave and sample consumer, acting mid-cycle
    initial forever begin
        @(negedge clk);
        if (rst) pend = 1'b0;
        if (pend) begin
            flash_mem_readdatavalid = 1'b1;
            flash_mem_readdata = flash[paddr];
            pend = 1'b0;
        end else if (stray_req) begin
            flash_mem_readdatavalid = 1'b1;
            flash_mem_readdata = 32'hDEAD_BEEF;
            stray_req = 1'b0;
        end else begin
            flash_mem_readdatavalid = 1'b0;
            flash_mem_readdata = $urandom;
        end
        if (prev_stall && !rst) begin
            check("read_held", {31'd0, flash_mem_read}, 32'd1);
            check("addr_held", {9'd0, flash_mem_address}, {9'd0, prev_addr});
        end
        case (wr_mode)
            1: flash_mem_waitrequest = ($urandom_range(0, 3) == 0);
            2: begin
                flash_mem_waitrequest = flash_mem_read && acc_cnt == 1 && stall_left > 0;
                if (flash_mem_waitrequest) begin
                    stall_left--;
                    stall_cycles++;
                end
            end
            default: flash_mem_waitrequest = 1'b0;
        endcase
        prev_stall = flash_mem_read && flash_mem_waitrequest && !rst;
        prev_addr = flash_mem_address;
        if (flash_mem_read && !flash_mem_waitrequest && !rst) begin
            if (acc_cnt == 0) first_addr = flash_mem_address;
            if (first_acc < 0) first_acc = cyc;
            acc_cnt++;
            pend = 1'b1;
            paddr = int'(flash_mem_address[1:0]);
        end
        if (flash_mem_read && flash_mem_address > max_addr) max_addr = flash_mem_address;
        case (ready_mode)
            1: sample_ready = ($urandom_range(0, 2) != 0);
            2: sample_ready = 1'b0;
            default: sample_ready = 1'b1;
        endcase
        if (sample_valid && first_valid < 0) first_valid = cyc;
        if (sample_valid && sample_ready && !rst) begin
            got_q.push_back(sample_data);
            if (exp_q.size() > 0) check("sample", {16'd0, sample_data}, {16'd0, exp_q.pop_front()});
            else check("sample_extra", {16'd0, sample_data}, 32'h0001_0000);
        end
    end

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk);
        mode = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = 2'($urandom);
    endtask

    task automatic prep(input int wrm, input int rdm);
        acc_cnt = 0; max_addr = '0; first_acc = -1; first_valid = -1;
        got_q.delete(); wr_mode = wrm; ready_mode = rdm; stall_left = 5; stall_cycles = 0;
    endtask

    task automatic finish_run(input string tag, input bit chk_lat);
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_left"}, exp_q.size(), 32'd0);
        check({tag, "_reads"}, acc_cnt, NW);
        check({tag, "_first_addr"}, {9'd0, first_addr}, 32'd0);
        check({tag, "_max_addr"}, {9'd0, max_addr}, NW - 1);
        if (chk_lat) check({tag, "_latency"}, first_valid - first_acc, 32'd3);
    endtask

    task automatic run_play(input string tag, input logic [1:0] m, input int wrm, input int rdm, input bit chk_lat);
        build_exp(m);
        prep(wrm, rdm);
        pulse_start(m);
        finish_run(tag, chk_lat);
    endtask

    logic [15:0] slow_exp [4];

    initial begin
        for (int a = 0; a < NW; a++) flash[a] = {16'(a * 2 + 1), 16'(a * 2)};
        #1;
        check("rst_read", {31'd0, flash_mem_read}, 32'd0);
        check("rst_addr", {9'd0, flash_mem_address}, 32'd0);
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_data", {16'd0, sample_data}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("tied", {flash_mem_write, flash_mem_burstcount, flash_mem_byteenable, flash_mem_writedata[3:0]},
              {1'b0, 1'b1, 4'hF, 4'h0});
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_play("normal", 2'b00, 0, 0, 1'b1);
        check("normal_count", got_q.size(), 32'd8);
        run_play("chip", 2'b01, 0, 0, 1'b0);
        check("chip_count", got_q.size(), 32'd4);

        flash[0] = 32'hFFFF_8000;
        run_play("slow", 2'b10, 0, 0, 1'b0);
`ifdef SAMPLE_ATTEN_EN
        slow_exp = '{16'hFE00, 16'hFE00, 16'hFFFF, 16'hFFFF};
`else
        slow_exp = '{16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF};
`endif
        for (int i = 0; i < 4; i++) check("slow_word0", {16'd0, got_q[i]}, {16'd0, slow_exp[i]});
        check("slow_count", got_q.size(), 32'd16);

        for (int a = 0; a < NW; a++) flash[a] = {16'(a * 2 + 1), 16'(a * 2)};
        run_play("stall", 2'b00, 2, 0, 1'b0);
        check("stall_cycles", stall_cycles, 32'd5);
        check("stall_count", got_q.size(), 32'd8);

        build_exp(2'b00);
        prep(0, 2);
        pulse_start(2'b00);
        repeat (150) @(negedge clk);
        check("full_reads", acc_cnt, 32'd4);
        check("full_read_low", {31'd0, flash_mem_read}, 32'd0);
        check("full_valid", {31'd0, sample_valid}, 32'd1);
        check("full_busy_done", {30'd0, busy, done}, 32'b10);
        check("full_nopop", got_q.size(), 32'd0);
        ready_mode = 0;
        finish_run("full", 1'b0);
        check("full_count", got_q.size(), 32'd8);

        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < NW; a++) flash[a] = $urandom;
            run_play("rand", 2'($urandom_range(0, 3)), 1, 1, 1'b0);
        end

        build_exp(2'b00);
        prep(0, 0);
        pulse_start(2'b00);
        begin
            int k;
            for (k = 0; k < 200 && !(pend && acc_cnt == 2); k++) @(negedge clk);
            check("rst_reach_wait", {31'd0, pend}, 32'd1);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_read", {31'd0, flash_mem_read}, 32'd0);
        check("midrst_addr", {9'd0, flash_mem_address}, 32'd0);
        check("midrst_valid_data", {15'd0, sample_valid, sample_data}, 32'd0);
        check("midrst_busy_done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        stray_req = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            check("stray_valid", {31'd0, sample_valid}, 32'd0);
        end
        check("stray_busy", {30'd0, busy, done}, 32'd0);
        run_play("restart", 2'b00, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule

// File: doc/flash_sample_fetcher.md
Name: flash_sample_fetcher

Overview:
- Upstream stage of the audio playback path. Reads 32-bit words from on-board flash over the Avalon-MM `flash_mem_*` master interface.
- Splits each word into two signed 16-bit samples (low half first) and applies the playback-speed mode.
- Buffers samples in a small FIFO. The audio writer drains the FIFO through a valid/ready handshake.

Parameters:
- NUM_WORDS, 2097152, number of 32-bit flash words to play (addresses 0..NUM_WORDS-1).
- FIFO_DEPTH, 8, sample FIFO entries (power of two, >=4).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins playback from address 0
- mode  in  2  00 normal, 01 chipmunk (low half only), 10 slow (each sample twice), 11 treated as 00
- flash_mem_read  out  1  Avalon read request
- flash_mem_address  out  23  word address
- flash_mem_waitrequest  in  1  slave stall
- flash_mem_readdata  in  32  read data
- flash_mem_readdatavalid  in  1  read data qualifier
- flash_mem_write  out  1  tied 0
- flash_mem_burstcount  out  1  tied 1
- flash_mem_byteenable  out  4  tied 4'hF
- flash_mem_writedata  out  32  tied 0
- sample_data  out  16  FIFO head, signed
- sample_valid  out  1  FIFO not empty
- sample_ready  in  1  consumer accepts head this cycle
- busy  out  1  playback in progress
- done  out  1  all words fetched and FIFO drained

Behaviour:
- Reset (async, rst=1): state IDLE, flash_mem_read=0, flash_mem_address=0, FIFO flushed, sample_valid=0, sample_data=0, busy=0, done=0.
- A reset asserted mid-operation abandons any outstanding read. Late readdatavalid after reset release, while in IDLE, is ignored.
- mode is latched on the accepted start. Later changes have no effect until the next start.
- FSM states:
  - IDLE: start -> REQ, address=0, busy=1, done=0.
  - REQ: wait until FIFO free count >= need. need = 2 for normal/chipmunk, 4 for slow. Then assert flash_mem_read and hold read and address stable while waitrequest=1. Read is accepted on the first cycle with read=1 and waitrequest=0; deassert read next cycle -> WAIT.
  - WAIT: on readdatavalid, latch readdata -> SPLIT_LO. Only one read is outstanding at a time.
  - SPLIT_LO: push readdata[15:0] (twice over 2 cycles in slow mode). Then SPLIT_HI, or ADV in chipmunk mode.
  - SPLIT_HI: push readdata[31:16] (twice in slow mode) -> ADV.
  - ADV: if address == NUM_WORDS-1 -> DRAIN, else address+1 -> REQ.
  - DRAIN: when FIFO empty -> DONE.
  - DONE: done=1, busy=0. start -> REQ as from IDLE.
- Pushes are 1 sample/cycle. Overflow is impossible by construction because the room check happens before the read.
- Samples per word: 2 (normal), 1 (chipmunk), 4 (slow).
- start is ignored while busy=1.
- FIFO:
  - Pop when sample_valid & sample_ready.
  - Simultaneous push and pop on a non-empty FIFO keeps the count unchanged.
  - Push into an empty FIFO makes sample_valid go high the next cycle (registered head).
  - Pointers wrap modulo FIFO_DEPTH.
- Latency from read acceptance to the first sample_valid, with readdatavalid one cycle later: 3 cycles.

Optional Feature:
- Macro SAMPLE_ATTEN_EN.
- Defined: each sample is arithmetic-shifted right by 6 (sign-preserving, signed divide by 64 with floor) before the FIFO push, giving codec-safe volume.
- Undefined: samples are pushed unmodified.

Test Plan:
- Normal mode, NUM_WORDS=4, readdata = {addr*2+1, addr*2}, sample_ready=1, waitrequest=0, readdatavalid one cycle after the read -> sample stream 0,1,2,3,4,5,6,7; done=1 after the last pop; flash_mem_address never exceeds 3.
- Chipmunk mode, same data -> stream 0,2,4,6; 4 reads issued; done=1.
- Slow mode, word 0 = 0xFFFF_8000 -> 0x8000,0x8000,0xFFFF,0xFFFF. With SAMPLE_ATTEN_EN: 0xFE00,0xFE00,0xFFFF,0xFFFF.
- waitrequest high for 5 cycles on the second read -> read and address held stable all 5 cycles; exactly one transfer; no duplicated or missing samples.
- sample_ready=0 throughout, normal mode -> after 4 words the FIFO holds 8 samples and flash_mem_read stays 0. Raising sample_ready resumes in order with no loss.
- rst pulsed while in WAIT with a read outstanding -> all outputs at reset values immediately. A stray readdatavalid afterwards pushes nothing. A new start reads from address 0.
